// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised FIFO core.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Depth must be a power of two so the pointers can wrap for free.
    function automatic bit params_legal(input int width, input int depth,
                                        input int af_level, input int ae_level);
        bit ok;
        ok = (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0);
        ok = ok && (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
        return ok;
    endfunction

endpackage

// File: rtl/fifo_param_core_if.sv
// Request/status bundle between the FIFO core and its user; clk/rst stay outside.
interface fifo_param_core_if #(
    parameter int WIDTH = fifo_pkg::DEF_WIDTH,
    parameter int DEPTH = fifo_pkg::DEF_DEPTH
);
    localparam int AW = fifo_pkg::clog2(DEPTH);

    logic             clear;
    logic             write;
    logic             read;
    logic             err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [AW:0]      use_dw;
    logic             full_n;
    logic             empty_n;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, write, read, err_clr, data_in,
        input  data_out, use_dw, full_n, empty_n, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  clear, write, read, err_clr, data_in,
        output data_out, use_dw, full_n, empty_n, almost_full, almost_empty,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param_core.sv
// Parametrised synchronous FIFO: pointers, occupancy counter, registered status flags,
// sticky error flags and standard or first-word-fall-through read data.
module fifo_param_core
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = 0
) (
    input logic              clk,
    input logic              rst,
    fifo_param_core_if.slave bus
);

    localparam int          AW        = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_THR    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR    = (AW + 1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_CNT   = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("fifo_param_core: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      use_dw_q, use_dw_d;
    logic             full_n_q, full_n_d;
    logic             empty_n_q, empty_n_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] ram_rdata;
    logic             rd_ok;
    logic             wr_ok;
    logic             ovf_set;
    logic             udf_set;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wptr_q),
        .wdata_i (bus.data_in),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_ok   = bus.read & empty_n_q & ~bus.clear & ~rst;
        wr_ok   = bus.write & (full_n_q | rd_ok) & ~bus.clear & ~rst;
        ovf_set = bus.write & ~wr_ok & ~bus.clear;
        udf_set = bus.read & ~rd_ok & ~bus.clear;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        use_dw_d    = use_dw_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        data_out_d  = data_out_q;
        if (bus.clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            use_dw_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            data_out_d  = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + ONE_PTR;
            end
            if (rd_ok) begin
                rptr_d     = rptr_q + ONE_PTR;
                data_out_d = ram_rdata;
            end
            if (wr_ok && !rd_ok) begin
                use_dw_d = use_dw_q + ONE_CNT;
            end else if (rd_ok && !wr_ok) begin
                use_dw_d = use_dw_q - ONE_CNT;
            end
            // A fresh error on the clearing edge keeps the flag set.
            overflow_d  = (overflow_q & ~bus.err_clr) | ovf_set;
            underflow_d = (underflow_q & ~bus.err_clr) | udf_set;
        end
        full_n_d       = (use_dw_d != FULL_CNT);
        empty_n_d      = (use_dw_d != '0);
        almost_full_d  = (use_dw_d >= AF_THR);
        almost_empty_d = (use_dw_d <= AE_THR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            use_dw_q       <= '0;
            full_n_q       <= 1'b1;
            empty_n_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            data_out_q     <= '0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            use_dw_q       <= use_dw_d;
            full_n_q       <= full_n_d;
            empty_n_q      <= empty_n_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            data_out_q     <= data_out_d;
        end
    end

    // In FWFT mode the head word is shown directly; it is forced to zero while empty.
    assign bus.data_out     = (FWFT != 0) ? (empty_n_q ? ram_rdata : '0) : data_out_q;
    assign bus.use_dw       = use_dw_q;
    assign bus.full_n       = full_n_q;
    assign bus.empty_n      = empty_n_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param_core.sv
// Directed bench for fifo_param_core: a standard-read instance and an FWFT instance.
module tb_fifo_param_core;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    fifo_param_core_if #(.WIDTH(8), .DEPTH(32)) bus_a ();
    fifo_param_core_if #(.WIDTH(8), .DEPTH(32)) bus_b ();

    fifo_param_core #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fifo_param_core #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flushed(input string tag);
        chk({tag, "_use_dw"}, 32'(bus_a.use_dw), 32'd0);
        chk({tag, "_empty_n"}, 32'(bus_a.empty_n), 32'd0);
        chk({tag, "_full_n"}, 32'(bus_a.full_n), 32'd1);
        chk({tag, "_dout"}, 32'(bus_a.data_out), 32'd0);
        chk({tag, "_ovf"}, 32'(bus_a.overflow), 32'd0);
        chk({tag, "_udf"}, 32'(bus_a.underflow), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus_a.clear = 0; bus_a.write = 0; bus_a.read = 0; bus_a.err_clr = 0; bus_a.data_in = '0;
        bus_b.clear = 0; bus_b.write = 0; bus_b.read = 0; bus_b.err_clr = 0; bus_b.data_in = '0;
        step();
        step();
        chk("rst_use_dw", 32'(bus_a.use_dw), 32'd0);
        chk("rst_full_n", 32'(bus_a.full_n), 32'd1);
        chk("rst_empty_n", 32'(bus_a.empty_n), 32'd0);
        chk("rst_af", 32'(bus_a.almost_full), 32'd0);
        chk("rst_ae", 32'(bus_a.almost_empty), 32'd1);
        chk("rst_ovf", 32'(bus_a.overflow), 32'd0);
        chk("rst_udf", 32'(bus_a.underflow), 32'd0);
        chk("rst_dout", 32'(bus_a.data_out), 32'd0);
        chk("rst_b_empty_n", 32'(bus_b.empty_n), 32'd0);
        rst = 1'b0;

        // 1: fill 0x00..0x1F then drain in order, tracking thresholds
        bus_a.write = 1;
        for (int i = 0; i < 32; i++) begin
            bus_a.data_in = 8'(i);
            step();
            chk($sformatf("t1_wr%0d_use_dw", i), 32'(bus_a.use_dw), 32'(i + 1));
            chk($sformatf("t1_wr%0d_full_n", i), 32'(bus_a.full_n), (i == 31) ? 32'd0 : 32'd1);
            chk($sformatf("t1_wr%0d_af", i), 32'(bus_a.almost_full), (i + 1 >= 28) ? 32'd1 : 32'd0);
            chk($sformatf("t1_wr%0d_ae", i), 32'(bus_a.almost_empty), (i + 1 <= 4) ? 32'd1 : 32'd0);
        end
        bus_a.write = 0;
        bus_a.read = 1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk($sformatf("t1_rd%0d_dout", i), 32'(bus_a.data_out), 32'(i));
            chk($sformatf("t1_rd%0d_use_dw", i), 32'(bus_a.use_dw), 32'(31 - i));
            chk($sformatf("t1_rd%0d_full_n", i), 32'(bus_a.full_n), 32'd1);
            chk($sformatf("t1_rd%0d_ae", i), 32'(bus_a.almost_empty), (31 - i <= 4) ? 32'd1 : 32'd0);
        end
        bus_a.read = 0;
        chk("t1_empty_n", 32'(bus_a.empty_n), 32'd0);
        chk("t1_udf", 32'(bus_a.underflow), 32'd0);

        // 2: overflow on a 33rd write; the dropped word never appears
        bus_a.write = 1;
        for (int i = 0; i < 32; i++) begin
            bus_a.data_in = 8'(8'h40 + i);
            step();
        end
        bus_a.data_in = 8'hAA;
        step();
        chk("t2_ovf", 32'(bus_a.overflow), 32'd1);
        chk("t2_use_dw", 32'(bus_a.use_dw), 32'd32);
        bus_a.err_clr = 1;
        step();
        chk("t2_ovf_err_clr_vs_new", 32'(bus_a.overflow), 32'd1);
        bus_a.write = 0;
        bus_a.err_clr = 0;
        bus_a.read = 1;
        for (int i = 0; i < 32; i++) begin
            step();
            chk($sformatf("t2_rd%0d_dout", i), 32'(bus_a.data_out), 32'(8'h40 + i));
        end
        bus_a.read = 0;
        chk("t2_drained", 32'(bus_a.use_dw), 32'd0);
        chk("t2_ovf_sticky", 32'(bus_a.overflow), 32'd1);
        bus_a.err_clr = 1;
        step();
        bus_a.err_clr = 0;
        chk("t2_ovf_cleared", 32'(bus_a.overflow), 32'd0);

        // 3: read while empty together with a write
        bus_a.read = 1;
        bus_a.write = 1;
        bus_a.data_in = 8'h55;
        step();
        bus_a.write = 0;
        chk("t3_udf", 32'(bus_a.underflow), 32'd1);
        chk("t3_use_dw", 32'(bus_a.use_dw), 32'd1);
        chk("t3_empty_n", 32'(bus_a.empty_n), 32'd1);
        step();
        bus_a.read = 0;
        chk("t3_dout", 32'(bus_a.data_out), 32'h55);
        chk("t3_use_dw_after", 32'(bus_a.use_dw), 32'd0);
        bus_a.err_clr = 1;
        step();
        bus_a.err_clr = 0;
        chk("t3_udf_cleared", 32'(bus_a.underflow), 32'd0);

        // 4: steady read+write at full across pointer wrap
        bus_a.write = 1;
        for (int i = 0; i < 32; i++) begin
            bus_a.data_in = 8'(8'h10 + i);
            exp_q.push_back(8'(8'h10 + i));
            step();
        end
        bus_a.read = 1;
        for (int k = 0; k < 40; k++) begin
            bus_a.data_in = 8'(8'h77 + k);
            step();
            exp_v = exp_q.pop_front();
            exp_q.push_back(8'(8'h77 + k));
            chk($sformatf("t4_c%0d_dout", k), 32'(bus_a.data_out), 32'(exp_v));
            chk($sformatf("t4_c%0d_use_dw", k), 32'(bus_a.use_dw), 32'd32);
            chk($sformatf("t4_c%0d_full_n", k), 32'(bus_a.full_n), 32'd0);
            chk($sformatf("t4_c%0d_ovf", k), 32'(bus_a.overflow), 32'd0);
        end
        bus_a.write = 0;
        bus_a.read = 0;

        // 5: clear with concurrent traffic, then reset mid-fill
        rst = 1;
        step();
        rst = 0;
        bus_a.write = 1;
        for (int i = 0; i < 10; i++) begin
            bus_a.data_in = 8'(8'hC0 + i);
            step();
        end
        bus_a.write = 0;
        bus_a.read = 1;
        step();
        chk("t5_pre_dout", 32'(bus_a.data_out), 32'hC0);
        bus_a.clear = 1;
        bus_a.write = 1;
        bus_a.data_in = 8'hEE;
        step();
        bus_a.clear = 0;
        bus_a.write = 0;
        bus_a.read = 0;
        chk_flushed("t5_clear");
        bus_a.write = 1;
        for (int i = 0; i < 6; i++) begin
            bus_a.data_in = 8'(8'hD0 + i);
            step();
        end
        bus_a.write = 0;
        bus_a.read = 1;
        step();
        chk("t5_mid_dout", 32'(bus_a.data_out), 32'hD0);
        bus_a.write = 1;
        rst = 1;
        step();
        rst = 0;
        bus_a.write = 0;
        bus_a.read = 0;
        chk_flushed("t5_rst");

        // 6: FWFT instance shows the head word without a read
        bus_b.write = 1;
        bus_b.data_in = 8'h3C;
        step();
        bus_b.write = 0;
        chk("t6_empty_n", 32'(bus_b.empty_n), 32'd1);
        chk("t6_dout", 32'(bus_b.data_out), 32'h3C);
        step();
        chk("t6_dout_hold", 32'(bus_b.data_out), 32'h3C);
        bus_b.read = 1;
        step();
        bus_b.read = 0;
        chk("t6_popped_empty_n", 32'(bus_b.empty_n), 32'd0);
        chk("t6_popped_use_dw", 32'(bus_b.use_dw), 32'd0);
        bus_b.write = 1;
        bus_b.data_in = 8'h11;
        step();
        bus_b.data_in = 8'h22;
        step();
        bus_b.write = 0;
        chk("t6_head1", 32'(bus_b.data_out), 32'h11);
        bus_b.read = 1;
        step();
        bus_b.read = 0;
        chk("t6_head2", 32'(bus_b.data_out), 32'h22);
        chk("t6_use_dw", 32'(bus_b.use_dw), 32'd1);
        chk("t6_udf", 32'(bus_b.underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
